// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM burst arbiter: command encodings,
// command length width and the scheduler FSM state type.
package sdram_pkg;

    localparam int unsigned CMD_LEN_W = 9;
    localparam int unsigned STAT_W    = 16;

    localparam logic [1:0] CMD_WR  = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_REF = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sdram_burst_arbiter_if.sv
// Command port between the burst arbiter (master) and the SDRAM command
// engine (slave).
interface sdram_burst_arbiter_if #(
    parameter int unsigned ADDR_W = 22
) ();
    import sdram_pkg::*;

    logic                 cmd_req;
    logic [1:0]           cmd_type;
    logic [ADDR_W-1:0]    cmd_addr;
    logic [CMD_LEN_W-1:0] cmd_len;
    logic                 cmd_ack;
    logic                 cmd_done;

    modport master (
        output cmd_req, cmd_type, cmd_addr, cmd_len,
        input  cmd_ack, cmd_done
    );

    modport slave (
        input  cmd_req, cmd_type, cmd_addr, cmd_len,
        output cmd_ack, cmd_done
    );

endinterface

// File: rtl/sdram_ref_timer.sv
// Free-running refresh interval timer. Raises ref_pend at terminal count and
// flags a sticky ref_miss if the previous request was never serviced.
module sdram_ref_timer #(
    parameter int unsigned REF_PERIOD = 780
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ref_clr,
    output logic o_ref_pend,
    output logic o_ref_miss
);

    localparam int unsigned CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_ref_pend;
    logic             r_ref_miss;
    logic             w_tc;

    assign w_tc       = (r_cnt == CNT_W'(REF_PERIOD - 1));
    assign o_ref_pend = r_ref_pend;
    assign o_ref_miss = r_ref_miss;

    // Counter wraps at REF_PERIOD-1; a new request wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_ref_pend <= 1'b0;
            r_ref_miss <= 1'b0;
        end else begin
            r_cnt <= w_tc ? '0 : r_cnt + CNT_W'(1);
            if (w_tc) begin
                r_ref_pend <= 1'b1;
            end else if (i_ref_clr) begin
                r_ref_pend <= 1'b0;
            end
            if (w_tc && r_ref_pend && !i_ref_clr) begin
                r_ref_miss <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// SDRAM command scheduler: picks refresh, write-FIFO drain or read-FIFO fill,
// issues one burst at a time and tracks wrapping linear write/read addresses.
// Optional saturating per-type command counters: define SDRAM_ARB_STATS_EN.
module sdram_burst_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned USEDW_W     = 10,
    parameter int unsigned RFIFO_DEPTH = 512,
    parameter int unsigned REF_PERIOD  = 780
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr_enable,
    input  logic                   i_rd_enable,
    input  logic                   i_addr_clr,
    input  logic [USEDW_W-1:0]     i_wfifo_usedw,
    input  logic [USEDW_W-1:0]     i_rfifo_usedw,
    sdram_burst_arbiter_if.master  cmd_if,
    output logic                   o_busy,
    output logic                   o_ref_miss
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]      o_stat_wr,
    output logic [STAT_W-1:0]      o_stat_rd,
    output logic [STAT_W-1:0]      o_stat_ref
`endif
);

    localparam logic [USEDW_W-1:0]   WR_THR    = USEDW_W'(BURST_LEN);
    localparam logic [USEDW_W-1:0]   RD_THR    = USEDW_W'(RFIFO_DEPTH - BURST_LEN);
    localparam logic [ADDR_W-1:0]    ADDR_STEP = ADDR_W'(BURST_LEN);
    localparam logic [CMD_LEN_W-1:0] DATA_LEN  = CMD_LEN_W'(BURST_LEN);

    state_e               r_state;
    state_e               w_state_nxt;
    logic                 w_load;
    logic                 w_acked;

    logic                 r_cmd_req;
    logic [1:0]           r_cmd_type;
    logic [ADDR_W-1:0]    r_cmd_addr;
    logic [CMD_LEN_W-1:0] r_cmd_len;
    logic                 r_busy;

    logic [ADDR_W-1:0]    r_wr_addr;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic                 r_last_rd;
    logic                 r_inc_kill;

    logic                 w_ref_pend;
    logic                 w_ref_clr;
    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic                 w_any_ok;
    logic [1:0]           w_grant;

    assign cmd_if.cmd_req  = r_cmd_req;
    assign cmd_if.cmd_type = r_cmd_type;
    assign cmd_if.cmd_addr = r_cmd_addr;
    assign cmd_if.cmd_len  = r_cmd_len;
    assign o_busy          = r_busy;

    assign w_wr_ok   = i_wr_enable && (i_wfifo_usedw >= WR_THR);
    assign w_rd_ok   = i_rd_enable && (i_rfifo_usedw <= RD_THR);
    assign w_any_ok  = w_ref_pend || w_wr_ok || w_rd_ok;
    assign w_ref_clr = w_acked && (r_cmd_type == CMD_REF);

    sdram_ref_timer #(
        .REF_PERIOD (REF_PERIOD)
    ) u_ref_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ref_clr  (w_ref_clr),
        .o_ref_pend (w_ref_pend),
        .o_ref_miss (o_ref_miss)
    );

    // Grant selection: refresh first, then round-robin between write and read.
    always_comb begin
        w_grant = CMD_RD;
        if (w_ref_pend) begin
            w_grant = CMD_REF;
        end else if (w_wr_ok && w_rd_ok) begin
            w_grant = r_last_rd ? CMD_WR : CMD_RD;
        end else if (w_wr_ok) begin
            w_grant = CMD_WR;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state plus command load/accept strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_acked     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_ok) begin
                    w_state_nxt = ST_ISSUE;
                    w_load      = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (cmd_if.cmd_ack) begin
                    w_acked     = 1'b1;
                    w_state_nxt = cmd_if.cmd_done ? ST_IDLE : ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (cmd_if.cmd_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered command fields, held stable from load until ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd_req  <= 1'b0;
            r_cmd_type <= CMD_WR;
            r_cmd_addr <= '0;
            r_cmd_len  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            if (w_load) begin
                r_cmd_req  <= 1'b1;
                r_cmd_type <= w_grant;
                r_cmd_len  <= (w_grant == CMD_REF) ? '0 : DATA_LEN;
                case (w_grant)
                    CMD_WR:  r_cmd_addr <= r_wr_addr;
                    CMD_RD:  r_cmd_addr <= r_rd_addr;
                    default: r_cmd_addr <= '0;
                endcase
            end else if (w_acked) begin
                r_cmd_req <= 1'b0;
            end
        end
    end

    // Address counters and round-robin history; a clear during ISSUE also
    // cancels the increment that the eventual ack would have applied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_last_rd  <= 1'b1;
            r_inc_kill <= 1'b0;
        end else begin
            r_inc_kill <= (r_state == ST_ISSUE) && !w_acked && (i_addr_clr || r_inc_kill);
            if (i_addr_clr) begin
                r_wr_addr <= '0;
                r_rd_addr <= '0;
            end else if (w_acked && !r_inc_kill) begin
                if (r_cmd_type == CMD_WR) begin
                    r_wr_addr <= r_wr_addr + ADDR_STEP;
                end
                if (r_cmd_type == CMD_RD) begin
                    r_rd_addr <= r_rd_addr + ADDR_STEP;
                end
            end
            if (w_acked && (r_cmd_type != CMD_REF)) begin
                r_last_rd <= (r_cmd_type == CMD_RD);
            end
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_wr;
    logic [STAT_W-1:0] r_stat_rd;
    logic [STAT_W-1:0] r_stat_ref;

    assign o_stat_wr  = r_stat_wr;
    assign o_stat_rd  = r_stat_rd;
    assign o_stat_ref = r_stat_ref;

    // Saturating per-type counters of accepted commands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_wr  <= '0;
            r_stat_rd  <= '0;
            r_stat_ref <= '0;
        end else if (w_acked) begin
            if ((r_cmd_type == CMD_WR) && (r_stat_wr != '1)) begin
                r_stat_wr <= r_stat_wr + STAT_W'(1);
            end
            if ((r_cmd_type == CMD_RD) && (r_stat_rd != '1)) begin
                r_stat_rd <= r_stat_rd + STAT_W'(1);
            end
            if ((r_cmd_type == CMD_REF) && (r_stat_ref != '1)) begin
                r_stat_ref <= r_stat_ref + STAT_W'(1);
            end
        end
    end
`endif

endmodule
